counter_reader: RTL and testbench
=================================

# counter_reader

Requester side of the FIFO pop-counter read port. On a `start` pulse it sweeps counter indices 0..NUM_CNT-1 over the `req`/`idx` → `valid`/`data_out` handshake and captures each returned count into a snapshot register bank. It also flags counters that fail to answer. It sits between the counter block and the status/host logic, replacing the hand-driven `req`/`idx` sequencing used in counter benches.

## Interface
- `NUM_CNT`, 5: number of counters swept; indices 0..NUM_CNT-1; max 8 (3-bit `idx`).
- `DATA_W`, 5: counter data width.
- `TIMEOUT`, 8: max REQ cycles without `valid` before giving up on an index; ≥1.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in state IDLE_S.
- `idle`  in  1  counter block idle/readable; `req` is only driven high while `idle`=1.
- `valid`  in  1  counter block response strobe.
- `data_out`  in  DATA_W  count returned for the current `idx`.
- `req`  out  1  read request to the counter block.
- `idx`  out  3  counter index being requested.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE exits.
- `done`  out  1  one-cycle pulse at sweep end.
- `err`  out  1  equals |`timeout_mask`.
- `timeout_mask`  out  NUM_CNT  bit i set if index i timed out.
- `snap`  out  NUM_CNT*DATA_W  captured counts; slice i = bits [i*DATA_W +: DATA_W].

## Operation
- States: IDLE_S, REQ, GAP, DONE.
- IDLE_S: `req`=0, `busy`=0. If `start`=1: clear `snap` and `timeout_mask`, set `idx`=0 and wait counter=0, go to REQ.
- REQ: `req` = `idle`.
  - If `req`=1 and `valid`=1: `snap[idx]` ← `data_out`, go to GAP.
  - Else if `idle`=1: wait counter +1. When it reaches TIMEOUT, set `timeout_mask[idx]`, leave `snap[idx]`=0, go to GAP.
  - If `idle`=0: pause. `req`=0, wait counter frozen, stay in REQ with the same `idx`.
- GAP: `req`=0 for exactly one cycle. If `idx`=NUM_CNT-1, go to DONE. Else `idx`+1, wait counter=0, go to REQ.
- DONE: `done`=1 for one cycle, then IDLE_S. `idx` returns to 0.
- `valid` is ignored whenever `req`=0, including stray pulses in GAP, IDLE_S and the paused REQ.
- `start` is ignored while `busy`. A `start` in the DONE cycle is also ignored.
- `snap` and `timeout_mask` hold their values until the next accepted `start`.
- `data_out` is captured unmodified; there is no arithmetic on it.

## Timing
- Reset (`reset`=1 at an edge): state IDLE_S. `req`=0, `idx`=0, `busy`=0, `done`=0, `err`=0, `timeout_mask`=0, `snap`=0 after that edge.
- Reset mid-sweep aborts immediately. No `done` pulse is produced, and partial snapshots are cleared.
- `start` is sampled at edge E. `req`=1, `idx`=0 are visible after E (if `idle`=1), and `busy`=1 from E.
- Same-cycle responder: each index costs 2 cycles (REQ + GAP). A full sweep is 2*NUM_CNT cycles plus 1 DONE cycle, with `done` asserted in cycle 2*NUM_CNT+1 after E.
- Registered (1-cycle latency) responder: each index costs 3 cycles.
- Timeout path: after TIMEOUT cycles of REQ with `idle`=1, the state is GAP.
- `idx` is stable whenever `req`=1. `req` never stays high across an index change.

## Test plan
- Same-cycle responder returns counts 3,7,0,31,12 for idx 0..4. Pulse `start` → `snap` slices = 3,7,0,31,12; `done` at cycle 11 after start; `err`=0.
- Responder never answers idx 2 (`valid`=0). Required: `timeout_mask`=5'b00100, `err`=1, `snap[2]`=0, other slices correct, and idx 2 holds REQ for 8 cycles.
- Drop `idle` for 4 cycles while in REQ on idx 1. Required: `req`=0 during the drop, `idx` stays 1, no timeout, and the sweep resumes and completes with `done` 4 cycles late.
- Assert `reset` while in REQ on idx 3. Required: all outputs zero next cycle, no `done` pulse, and a following `start` sweeps from idx 0.
- Pulse `start` repeatedly while `busy`, and inject stray `valid` pulses in GAP/IDLE_S. Required: a single sweep, with `snap` unaffected by the stray `valid` pulses.
- Run back-to-back sweeps with different counts. Required: the second `start` clears `timeout_mask`/`snap`, and the results reflect only the second sweep.

Source files
------------

// File: rtl/counter_reader.sv
// Requester for the counter block read port: sweeps every counter index over
// req/idx -> valid/data_out and latches each answer (or a timeout) per index.

module counter_reader_slot #(
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              cap,
  input  logic              expire,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              tmo
);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q   <= '0;
      tmo <= 1'b0;
    end else begin
      if (cap)    q   <= d;
      if (expire) tmo <= 1'b1;
    end
  end
endmodule

module counter_reader #(
  parameter int NUM_CNT = 5,
  parameter int DATA_W  = 5,
  parameter int TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      idle,
  input  logic                      valid,
  input  logic [DATA_W-1:0]         data_out,
  output logic                      req,
  output logic [2:0]                idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [NUM_CNT-1:0]        timeout_mask,
  output logic [NUM_CNT*DATA_W-1:0] snap
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE_S, REQ, GAP, DONE} state_t;

  state_t                          state;
  logic [CW-1:0]                   wait_cnt;
  logic                            clr, hit, expire;
  logic [NUM_CNT-1:0][DATA_W-1:0]  snap_q;
  logic [NUM_CNT-1:0]              tmo_q;

  // req follows idle combinationally so a busy counter block pauses the sweep
  // in the same cycle without a stale request.
  assign req    = (state == REQ) && idle;
  assign clr    = (state == IDLE_S) && start;
  assign hit    = req && valid;
  assign expire = req && !valid && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE_S;
      idx      <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE_S: begin
          done <= 1'b0;
          if (start) begin
            state    <= REQ;
            idx      <= '0;
            wait_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        REQ: begin
          if (hit) begin
            state <= GAP;
          end else if (idle) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (expire) state <= GAP;
          end
        end
        GAP: begin
          if (idx == 3'(NUM_CNT - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx      <= idx + 3'd1;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE_S;
        end
        default: state <= IDLE_S;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_slot
    counter_reader_slot #(.DATA_W(DATA_W)) u_slot (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .cap    (hit && (idx == 3'(i))),
      .expire (expire && (idx == 3'(i))),
      .d      (data_out),
      .q      (snap_q[i]),
      .tmo    (tmo_q[i])
    );
  end

  assign snap         = snap_q;
  assign timeout_mask = tmo_q;
  assign err          = |tmo_q;
endmodule

// File: tb/tb_counter_reader.sv
// Randomized bench for counter_reader: a latency-programmable responder plus a
// per-sweep model of duration, snapshot contents and timeout mask.

module tb_counter_reader;
  localparam int NUM = 5;
  localparam int DW  = 5;
  localparam int TO  = 8;

  logic              clk = 1'b0;
  logic              reset, start, idle, valid;
  logic [DW-1:0]     data_out;
  logic              req, busy, done, err;
  logic [2:0]        idx;
  logic [NUM-1:0]    timeout_mask;
  logic [NUM*DW-1:0] snap;

  counter_reader #(.NUM_CNT(NUM), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .idle(idle), .valid(valid),
    .data_out(data_out), .req(req), .idx(idx), .busy(busy), .done(done),
    .err(err), .timeout_mask(timeout_mask), .snap(snap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // responder configuration: answer on the (lat+1)-th requested cycle of each index
  logic [DW-1:0] cv [NUM];
  int            lat [NUM];
  int            hold [NUM];
  bit            idle_pat [256];
  bit            stray, spam;
  int            rcnt, last_idx;
  logic          prev_req;
  logic [2:0]    prev_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit idle_at(input int t);
    return (t < 256) ? idle_pat[t] : 1'b1;
  endfunction

  // cycle (relative to the start edge) in which done must be seen
  function automatic int model_done();
    int t = 1;
    for (int i = 0; i < NUM; i++) begin
      int n = 0;
      bit fin = 0;
      while (!fin) begin
        if (idle_at(t)) begin
          n++;
          if (lat[i] < TO && n == lat[i] + 1) fin = 1;
          else if (n == TO) fin = 1;
        end
        t++;
      end
      t++;
    end
    return t;
  endfunction

  task automatic drive(input int t);
    @(negedge clk);
    idle  = idle_at(t);
    start = spam && ($urandom_range(0, 2) == 0);
    #1;
    if (req) begin
      chk("req_idle", {63'd0, idle}, 64'd1);
      if (prev_req) chk("idx_stable", {61'd0, idx}, {61'd0, prev_idx});
      if (int'(idx) != last_idx) begin
        rcnt = 0;
        last_idx = int'(idx);
      end
      hold[idx]++;
      valid    = (rcnt >= lat[idx]);
      data_out = valid ? cv[idx] : DW'($urandom);
      rcnt++;
    end else begin
      valid    = stray && ($urandom_range(0, 3) == 0);
      data_out = DW'($urandom);
    end
    prev_req = req;
    prev_idx = idx;
  endtask

  task automatic check_results(input string tag);
    logic [NUM-1:0] emask;
    emask = '0;
    for (int i = 0; i < NUM; i++) begin
      emask[i] = (lat[i] >= TO);
      chk({tag, "_snap"}, {59'd0, snap[i*DW +: DW]}, {59'd0, (lat[i] >= TO) ? DW'(0) : cv[i]});
    end
    chk({tag, "_mask"}, {59'd0, timeout_mask}, {59'd0, emask});
    chk({tag, "_err"}, {63'd0, err}, {63'd0, |emask});
  endtask

  task automatic sweep();
    int exp_t, got_t;
    exp_t = model_done();
    @(negedge clk);
    start = 1; idle = 1; valid = 0;
    rcnt = 0; last_idx = 0; prev_req = 0;
    for (int i = 0; i < NUM; i++) hold[i] = 0;
    got_t = 0;
    for (int t = 1; t < 300; t++) begin
      drive(t);
      if (t == 1) begin
        chk("busy_start", {63'd0, busy}, 64'd1);
        if (idle_at(1)) begin
          chk("req_first", {63'd0, req}, 64'd1);
          chk("idx_first", {61'd0, idx}, 64'd0);
        end
      end
      if (done) begin
        got_t = t;
        break;
      end
    end
    if (got_t == 0) chk("done_seen", 64'd0, 64'd1);
    else begin
      chk("done_cycle", got_t, exp_t);
      chk("busy_done", {63'd0, busy}, 64'd1);
      for (int i = 0; i < NUM; i++)
        chk("req_hold", hold[i], (lat[i] >= TO) ? TO : lat[i] + 1);
    end
    @(negedge clk);
    start = 0; valid = stray; data_out = DW'($urandom);
    #1;
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("done_pulse", {63'd0, done}, 64'd0);
    check_results("sweep");
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, {63'd0, req}, 64'd0);
    chk({tag, "_idx"}, {61'd0, idx}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_mask"}, {59'd0, timeout_mask}, 64'd0);
    chk({tag, "_snap"}, {39'd0, snap}, 64'd0);
  endtask

  task automatic plain_cfg();
    for (int i = 0; i < 256; i++) idle_pat[i] = 1;
    for (int i = 0; i < NUM; i++) lat[i] = 0;
    stray = 0; spam = 0;
  endtask

  initial begin
    reset = 1; start = 0; idle = 1; valid = 0; data_out = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check_zero("reset");

    // same-cycle responder, known counts
    plain_cfg();
    cv = '{5'd3, 5'd7, 5'd0, 5'd31, 5'd12};
    sweep();

    // idx 2 never answers
    plain_cfg();
    lat[2] = 1000;
    sweep();

    // idle drop of 4 cycles on idx 1 (cycles 3..6)
    plain_cfg();
    for (int t = 3; t <= 6; t++) idle_pat[t] = 0;
    sweep();

    // start spam and stray valid pulses
    plain_cfg();
    stray = 1; spam = 1;
    cv = '{5'd21, 5'd1, 5'd30, 5'd9, 5'd17};
    sweep();

    // back-to-back: timeouts then clean sweep with new counts
    plain_cfg();
    lat[1] = 50; lat[3] = 50; lat[4] = 1;
    cv = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    sweep();
    plain_cfg();
    cv = '{5'd11, 5'd22, 5'd13, 5'd24, 5'd15};
    sweep();

    // reset while requesting idx 3
    plain_cfg();
    @(negedge clk);
    start = 1; rcnt = 0; last_idx = 0; prev_req = 0;
    begin
      bit hit3 = 0;
      for (int t = 1; t < 100 && !hit3; t++) begin
        drive(t);
        if (req && idx == 3'd3) hit3 = 1;
      end
      chk("reach_idx3", {63'd0, hit3}, 64'd1);
    end
    reset = 1;
    @(negedge clk);
    #1;
    check_zero("abort");
    reset = 0;
    cv = '{5'd2, 5'd4, 5'd8, 5'd16, 5'd1};
    sweep();

    // randomized sweeps
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 256; i++) idle_pat[i] = ($urandom_range(0, 99) >= 15);
      for (int i = 0; i < NUM; i++) begin
        int r = $urandom_range(0, 9);
        cv[i]  = DW'($urandom);
        lat[i] = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? $urandom_range(2, TO - 1)
                                                       : $urandom_range(TO, TO + 20);
      end
      stray = 1; spam = $urandom_range(0, 1);
      sweep();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
